// File: rtl/mem_access_unit.sv
// Load/store access sequencer between the execute stage and a 64-bit doubleword memory port.
// Optional feature: define MEM_MISALIGN_TRAP_EN to report misaligned accesses instead of aligning them.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_valid,
  output logic              core_ready,
  input  logic              core_we,
  input  logic [2:0]        core_funct3,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [63:0]       core_wdata,
  output logic              core_done,
  output logic [63:0]       core_rdata,
  output logic              core_misalign,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [63:0]       mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [63:0]       mem_resp_data
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned MASK_W = 8;
  localparam int unsigned OFF_W  = 3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [2:0]         lat_funct3;
  logic [OFF_W-1:0]   lat_off;
  logic [OFF_W-1:0]   off_raw_c, off_c, align_mask_c;
  logic [MASK_W-1:0]  base_mask_c;
  logic               misalign_c;
  logic               accept_c;

  // Shift the returned doubleword down to the accessed lane and extend to 64 bits.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] d,
                                                     input logic [OFF_W-1:0]  off,
                                                     input logic [2:0]        f3);
    logic [DATA_W-1:0] s;
    s = d >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{56{s[7]}},  s[7:0]};
      3'b001:  load_extend = {{48{s[15]}}, s[15:0]};
      3'b010:  load_extend = {{32{s[31]}}, s[31:0]};
      3'b100:  load_extend = {56'd0, s[7:0]};
      3'b101:  load_extend = {48'd0, s[15:0]};
      3'b110:  load_extend = {32'd0, s[31:0]};
      default: load_extend = s;
    endcase
  endfunction

  // Size decode from the incoming request: lane mask base and natural-alignment mask.
  always_comb begin
    off_raw_c    = core_addr[OFF_W-1:0];
    align_mask_c = 3'b111;
    base_mask_c  = 8'h01;
    case (core_funct3[1:0])
      2'd0:    begin align_mask_c = 3'b111; base_mask_c = 8'h01; end
      2'd1:    begin align_mask_c = 3'b110; base_mask_c = 8'h03; end
      2'd2:    begin align_mask_c = 3'b100; base_mask_c = 8'h0F; end
      default: begin align_mask_c = 3'b000; base_mask_c = 8'hFF; end
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    off_c      = off_raw_c;
    misalign_c = |(off_raw_c & ~align_mask_c);
`else
    off_c      = off_raw_c & align_mask_c;
    misalign_c = 1'b0;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      IDLE: if (core_valid) begin
        accept_c  = 1'b1;
        state_nxt = misalign_c ? DONE : REQ;
      end
      REQ:  if (mem_req_ready)  state_nxt = WAIT;
      WAIT: if (mem_resp_valid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      lat_funct3     <= '0;
      lat_off        <= '0;
      core_ready     <= 1'b1;
      core_done      <= 1'b0;
      core_rdata     <= '0;
      core_misalign  <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_we     <= 1'b0;
      mem_req_wdata  <= '0;
      mem_req_wmask  <= '0;
      mem_resp_ready <= 1'b0;
    end else begin
      state          <= state_nxt;
      core_ready     <= (state_nxt == IDLE);
      core_done      <= (state_nxt == DONE);
      mem_req_valid  <= (state_nxt == REQ);
      mem_resp_ready <= (state_nxt == WAIT);
      if (accept_c) begin
        lat_funct3    <= core_funct3;
        lat_off       <= off_c;
        core_misalign <= misalign_c;
        mem_req_addr  <= {core_addr[ADDR_W-1:OFF_W], 3'b000};
        mem_req_we    <= core_we;
        mem_req_wdata <= core_wdata << {off_c, 3'b000};
        mem_req_wmask <= core_we ? MASK_W'(base_mask_c << off_c) : '0;
      end
      if (state == WAIT && mem_resp_valid) begin
        core_rdata <= mem_req_we ? '0 : load_extend(mem_resp_data, lat_off, lat_funct3);
      end
      if (state == DONE) begin
        core_rdata    <= '0;
        core_misalign <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with an inline memory responder.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_valid, core_ready, core_we;
  logic [2:0]  core_funct3;
  logic [63:0] core_addr, core_wdata;
  logic        core_done;
  logic [63:0] core_rdata;
  logic        core_misalign;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_we;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid, mem_resp_ready;
  logic [63:0] mem_resp_data;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_ready(core_ready), .core_we(core_we),
    .core_funct3(core_funct3), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_done(core_done), .core_rdata(core_rdata), .core_misalign(core_misalign),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mdata;
    int          rqw;
    int          rsw;
    logic        pulse;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic [7:0]  exp_mask;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
    logic        exp_mis;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] mdata,
                              input int rqw, input int rsw, input logic pulse,
                              input logic exp_req, input logic [63:0] exp_addr,
                              input logic [7:0] exp_mask, input logic [63:0] exp_wdata,
                              input logic [63:0] exp_rdata, input logic exp_mis, input int exp_cyc);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mdata = mdata;
    v.rqw = rqw; v.rsw = rsw; v.pulse = pulse; v.exp_req = exp_req;
    v.exp_addr = exp_addr; v.exp_mask = exp_mask; v.exp_wdata = exp_wdata;
    v.exp_rdata = exp_rdata; v.exp_mis = exp_mis; v.exp_cyc = exp_cyc;
    return v;
  endfunction

  // Issue one access from IDLE and act as the memory until core_done, then step back to IDLE.
  task automatic run(input int idx, input vec_t v);
    logic [63:0] a0, w0, rd;
    logic [7:0]  m0;
    logic        we0, mis;
    bit          seen, stable;
    int          rq, rs, dc;
    string       tag;
    a0 = '0; w0 = '0; m0 = '0; we0 = 1'b0; rd = '0; mis = 1'b0;
    seen = 0; stable = 1; rq = 0; rs = 0; dc = -1;
    tag = $sformatf("v%0d", idx);
    chk({tag, "_ready"}, 64'(core_ready), 64'd1);
    core_valid = 1'b1; core_we = v.we; core_funct3 = v.f3;
    core_addr = v.addr; core_wdata = v.wdata; mem_resp_data = v.mdata;
    @(posedge clk); #1;
    core_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (core_done) begin
        dc = c; rd = core_rdata; mis = core_misalign;
        break;
      end
      if (v.pulse) begin
        core_valid = c[0];
        core_addr  = 64'hDEAD_0000;
        core_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      if (mem_req_valid) begin
        if (!seen) begin
          a0 = mem_req_addr; w0 = mem_req_wdata; m0 = mem_req_wmask; we0 = mem_req_we;
        end else if (a0 !== mem_req_addr || w0 !== mem_req_wdata ||
                     m0 !== mem_req_wmask || we0 !== mem_req_we) begin
          stable = 0;
        end
        seen = 1;
        mem_req_ready = (rq >= v.rqw);
        rq++;
      end else begin
        mem_req_ready = 1'b0;
      end
      if (mem_resp_ready) begin
        mem_resp_valid = (rs >= v.rsw);
        rs++;
      end else begin
        mem_resp_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    core_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    chk({tag, "_done_cycle"}, 64'(dc), 64'(v.exp_cyc));
    chk({tag, "_rdata"}, rd, v.exp_rdata);
    chk({tag, "_misalign"}, 64'(mis), 64'(v.exp_mis));
    chk({tag, "_req_seen"}, 64'(seen), 64'(v.exp_req));
    if (v.exp_req && seen) begin
      chk({tag, "_req_addr"}, a0, v.exp_addr);
      chk({tag, "_req_we"}, 64'(we0), 64'(v.we));
      chk({tag, "_req_wmask"}, 64'(m0), 64'(v.exp_mask));
      chk({tag, "_req_wdata"}, w0, v.exp_wdata);
      chk({tag, "_req_stable"}, 64'(stable), 64'd1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit          trap;
    bit          got;
    logic [63:0] lw_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = 1;
`else
    trap = 0;
`endif
    rst = 1'b1; core_valid = 1'b0; core_we = 1'b0; core_funct3 = '0;
    core_addr = '0; core_wdata = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;

    //       we  f3      addr          wdata                  mdata                  rqw rsw pls req exp_addr       mask   exp_wdata              exp_rdata              mis cyc
    vecs[0]  = mk(0, 3'b011, 64'h1000, 64'h0,                 64'h1122334455667788,  0, 0, 0, 1, 64'h1000, 8'h00, 64'h0,                 64'h1122334455667788,  0, 3);
    vecs[1]  = mk(0, 3'b000, 64'h1003, 64'h0,                 64'h0000000080000000,  0, 0, 0, 1, 64'h1000, 8'h00, 64'h0,                 64'hFFFFFFFFFFFFFF80,  0, 3);
    vecs[2]  = mk(0, 3'b100, 64'h1003, 64'h0,                 64'h0000000080000000,  0, 0, 0, 1, 64'h1000, 8'h00, 64'h0,                 64'h0000000000000080,  0, 3);
    vecs[3]  = mk(1, 3'b001, 64'h2006, 64'hBEEF,              64'h5555555555555555,  0, 0, 0, 1, 64'h2000, 8'hC0, 64'hBEEF000000000000,  64'h0,                 0, 3);
    vecs[4]  = mk(0, 3'b010, 64'h3004, 64'h0,                 64'hDEADBEEF12345678,  3, 2, 1, 1, 64'h3000, 8'h00, 64'h0,                 64'hFFFFFFFFDEADBEEF,  0, 8);
    vecs[5]  = mk(0, 3'b101, 64'h5002, 64'h0,                 64'h0000000080010000,  1, 1, 0, 1, 64'h5000, 8'h00, 64'h0,                 64'h0000000000008001,  0, 5);
    vecs[6]  = mk(0, 3'b001, 64'h5002, 64'h0,                 64'h0000000080010000,  0, 0, 0, 1, 64'h5000, 8'h00, 64'h0,                 64'hFFFFFFFFFFFF8001,  0, 3);
    vecs[7]  = mk(1, 3'b000, 64'h6007, 64'h123456789ABCDEAB,  64'h0,                 0, 0, 0, 1, 64'h6000, 8'h80, 64'hAB00000000000000,  64'h0,                 0, 3);
    vecs[8]  = mk(1, 3'b110, 64'h7004, 64'hCAFEF00D,          64'h0,                 0, 0, 0, 1, 64'h7000, 8'hF0, 64'hCAFEF00D00000000,  64'h0,                 0, 3);
    vecs[9]  = mk(1, 3'b011, 64'h8000, 64'h0123456789ABCDEF,  64'h0,                 0, 0, 0, 1, 64'h8000, 8'hFF, 64'h0123456789ABCDEF,  64'h0,                 0, 3);
    vecs[10] = mk(0, 3'b110, 64'h9004, 64'h0,                 64'h8765432100000000,  0, 0, 0, 1, 64'h9000, 8'h00, 64'h0,                 64'h0000000087654321,  0, 3);
    vecs[11] = mk(0, 3'b111, 64'hA000, 64'h0,                 64'hFEDCBA9876543210,  0, 0, 0, 1, 64'hA000, 8'h00, 64'h0,                 64'hFEDCBA9876543210,  0, 3);
    // Misaligned LW: trapped straight to DONE, or aligned down to offset 0.
    lw_rdata = trap ? 64'h0 : 64'hFFFFFFFF80000000;
    vecs[12] = mk(0, 3'b010, 64'h4002, 64'h0,                 64'h1111111180000000,  0, 0, 0, !trap, 64'h4000, 8'h00, 64'h0,          lw_rdata,              trap, trap ? 1 : 3);

    @(posedge clk); @(posedge clk); #1;
    chk("rst_core_ready", 64'(core_ready), 64'd1);
    chk("rst_core_done", 64'(core_done), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_resp_ready", 64'(mem_resp_ready), 64'd0);
    chk("rst_core_rdata", core_rdata, 64'd0);
    chk("rst_wmask", 64'(mem_req_wmask), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run(i, vecs[i]);

    // Reset while waiting for the response.
    core_valid = 1'b1; core_we = 1'b0; core_funct3 = 3'b011; core_addr = 64'h1000;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    core_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_resp_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    chk("rstwait_reached_wait", 64'(got), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstwait_core_ready", 64'(core_ready), 64'd1);
    chk("rstwait_resp_ready", 64'(mem_resp_ready), 64'd0);
    chk("rstwait_done", 64'(core_done), 64'd0);
    mem_resp_valid = 1'b1;
    got = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (core_done || !core_ready) got = 1;
    end
    mem_resp_valid = 1'b0;
    chk("rstwait_no_done_after", 64'(got), 64'd0);

    // Reset while the request is pending deasserts mem_req_valid.
    core_valid = 1'b1; core_funct3 = 3'b011; core_addr = 64'h2000;
    @(posedge clk); #1;
    core_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstreq_valid_before", 64'(mem_req_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstreq_valid_after", 64'(mem_req_valid), 64'd0);
    chk("rstreq_core_ready", 64'(core_ready), 64'd1);

    // Unit is usable again after reset.
    run(100, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access sequencer between the core's execute stage and the data memory port. It accepts one load or store from the core and drives a valid/ready request/response transaction on a 64-bit doubleword memory interface. For stores it builds the byte mask and lane-shifted write data; for loads it lane-shifts and sign- or zero-extends the returned doubleword. It produces the aligned value consumed as the MEM input of the writeback select, and holds the core stalled while an access is in flight.

## Interface
- ADDR_W, 64, byte-address width on both core and memory sides.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- core_valid  in  1  access request from core.
- core_ready  out  1  unit can accept a request; high only in IDLE.
- core_we  in  1  1 = store, 0 = load.
- core_funct3  in  3  RV64 width/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- core_addr  in  ADDR_W  byte address.
- core_wdata  in  64  store data, right-aligned.
- core_done  out  1  one-cycle pulse: access complete.
- core_rdata  out  64  extended load data; valid while core_done=1, 0 for stores.
- core_misalign  out  1  valid with core_done; see Configuration.
- mem_req_valid / mem_req_ready  out / in  1  request handshake.
- mem_req_addr  out  ADDR_W  doubleword-aligned address (core_addr with bits [2:0] zeroed).
- mem_req_we  out  1  write enable.
- mem_req_wdata  out  64  lane-shifted store data.
- mem_req_wmask  out  8  byte enables; 0 for loads.
- mem_resp_valid / mem_resp_ready  in / out  1  response handshake.
- mem_resp_data  in  64  read doubleword; ignored for stores (the response is the write ack).

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: core_ready=1. On core_valid, latch we, funct3, addr, wdata, and go to REQ.
- REQ: mem_req_valid=1. Address, we, wdata, and wmask come from latched values and stay stable until the handshake. On mem_req_ready, go to WAIT.
- WAIT: mem_resp_ready=1. On mem_resp_valid, latch the extended result and go to DONE.
- DONE: core_done=1 for exactly one cycle, then IDLE.
- Size from funct3[1:0]: 1, 2, 4, or 8 bytes. With off = addr[2:0]:
  - wmask = {1,3,F,FF}[size] << off.
  - wdata = core_wdata << (8*off).
- Load data: shifted = mem_resp_data >> (8*off), then truncated to size.
  - Sign-extended when funct3[2]=0; zero-extended when funct3[2]=1.
  - funct3=111 behaves as 011 (LD).
  - Stores ignore funct3[2].
- A response arriving in any state other than WAIT is not accepted (mem_resp_ready=0).
- Only one access is outstanding; no queueing.

## Timing
- Reset values: state IDLE, core_ready=1, all other outputs 0, latched registers 0.
- Minimum latency with mem_req_ready tied 1 and a 1-cycle memory: accept at cycle 0, request handshake at cycle 1, response at cycle 2, core_done at cycle 3.
- Each extra cycle of mem_req_ready=0 or mem_resp_valid=0 adds one cycle.
- core_valid is ignored outside IDLE. A new request can be accepted the cycle after core_done.
- rst in any state returns the unit to IDLE next edge and deasserts mem_req_valid. The memory responder shares rst, so no stale response survives.
- The address-offset arithmetic uses addr[2:0] only. Upper address bits pass through unchanged, so there is no wrap handling.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - In IDLE, an access with addr not a multiple of its size goes straight to DONE.
  - No memory request is issued.
  - core_misalign=1 and core_rdata=0 with the core_done pulse.
- Not defined:
  - Offset is forced to natural alignment: off & ~(size-1).
  - core_misalign is tied 0.

## Test plan
- LD at 0x1000, memory returns 0x1122334455667788 with 0-wait -> core_done at cycle 3, core_rdata=0x1122334455667788.
- LB at 0x1003 with data 0x00000000_80000000 -> core_rdata=0xFFFFFFFFFFFFFF80. LBU at the same address and data -> 0x80.
- SH 0xBEEF at 0x2006 -> mem_req_addr=0x2000, wmask=0xC0, wdata[63:48]=0xBEEF. On ack, core_done=1 and core_rdata=0.
- LW at 0x3004 with mem_req_ready low for 3 cycles and response delayed 2 cycles:
  - Request fields stay stable throughout.
  - core_done arrives at cycle 8.
  - core_valid pulses during the access are ignored.
- rst asserted in WAIT -> next cycle state IDLE, core_ready=1, no core_done.
- LW at 0x4002:
  - With MEM_MISALIGN_TRAP_EN: core_misalign=1, core_done at cycle 1, no mem_req_valid.
  - Without: request issued and data taken from offset 0.
